// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
package alu_share_pkg;

    localparam int unsigned ALU_WIDTH_DEF = 8;
    localparam int unsigned ALU_OPW_DEF   = 4;
    localparam int unsigned CNT_W_DEF     = 16;

    localparam int unsigned FLAG_CF = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_ZF = 1;
    localparam int unsigned FLAG_NF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request and response channels between the two issue ports and the arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone valid always wins, rr_ptr breaks ties.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        if (valid == 2'b11) begin
            gnt_id = rr_ptr;
        end else begin
            gnt_id = valid[1];
        end
        if (valid != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 8-bit ALU between two valid/ready requesters, IDLE -> EXEC -> RESP.
// Optional per-requester grant counters under ALU_SHARE_ARB_CNT_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF,
    parameter int unsigned OPW   = ALU_OPW_DEF
`ifdef ALU_SHARE_ARB_CNT_EN
    , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst,
    alu_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cf,
    input  logic             alu_of,
    input  logic             alu_zf,
    input  logic             alu_nf
`ifdef ALU_SHARE_ARB_CNT_EN
    , output logic [CNT_W-1:0] gnt0_cnt
    , output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;

    logic [1:0] gnt;
    logic       gnt_id;
    logic [1:0] ready_c;
    logic       accept_c;

    rr_arb2 u_rr_arb2 (
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Next-state and datapath load; ready is only offered to the IDLE winner.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        ready_c      = 2'b00;
        accept_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    ready_c  = gnt;
                    accept_c = 1'b1;
                    id_d     = gnt_id;
                    rr_ptr_d = ~gnt_id;
                    alu_a_d  = gnt_id ? bus.req1_a  : bus.req0_a;
                    alu_b_d  = gnt_id ? bus.req1_b  : bus.req0_b;
                    alu_op_d = gnt_id ? bus.req1_op : bus.req0_op;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d          = alu_result;
                rsp_flags_d[FLAG_CF]  = alu_cf;
                rsp_flags_d[FLAG_OF]  = alu_of;
                rsp_flags_d[FLAG_ZF]  = alu_zf;
                rsp_flags_d[FLAG_NF]  = alu_nf;
                rsp_id_d              = id_q;
                rsp_valid_d           = 1'b1;
                state_d               = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

`ifdef ALU_SHARE_ARB_CNT_EN
    logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;

    // Counters wrap naturally at all-ones.
    always_comb begin
        gnt0_cnt_d = gnt0_cnt_q + CNT_W'(accept_c & ~gnt_id);
        gnt1_cnt_d = gnt1_cnt_q + CNT_W'(accept_c & gnt_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
        end else begin
            gnt0_cnt_q <= gnt0_cnt_d;
            gnt1_cnt_q <= gnt1_cnt_d;
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif

    assign bus.req0_ready = ready_c[0];
    assign bus.req1_ready = ready_c[1];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_opcode     = alu_op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU_8bit.
// Also checks the grant counters when ALU_SHARE_ARB_CNT_EN is defined.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_opcode;
    logic       alu_cf, alu_of, alu_zf, alu_nf;
`ifdef ALU_SHARE_ARB_CNT_EN
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    alu_share_arbiter_if #(.WIDTH(8), .OPW(4)) bus ();

    alu_share_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_cf     (alu_cf),
        .alu_of     (alu_of),
        .alu_zf     (alu_zf),
        .alu_nf     (alu_nf)
`ifdef ALU_SHARE_ARB_CNT_EN
        , .gnt0_cnt (gnt0_cnt)
        , .gnt1_cnt (gnt1_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: 0=ADD, 1=SUB (cf = borrow), 2=AND, others pass a.
    logic [8:0] wide;
    always_comb begin
        wide   = {1'b0, alu_a};
        alu_of = 1'b0;
        case (alu_opcode)
            4'h0: begin
                wide   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_of = (alu_a[7] == alu_b[7]) && (wide[7] != alu_a[7]);
            end
            4'h1: begin
                wide   = {1'b0, alu_a} - {1'b0, alu_b};
                alu_of = (alu_a[7] != alu_b[7]) && (wide[7] != alu_a[7]);
            end
            4'h2: wide = {1'b0, alu_a & alu_b};
            default: wide = {1'b0, alu_a};
        endcase
        alu_result = wide[7:0];
        alu_cf     = wide[8];
        alu_zf     = (wide[7:0] == 8'h00);
        alu_nf     = wide[7];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] op);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs[5];
    logic [7:0] hold_res;
    logic [3:0] hold_flags;

    initial begin
        vecs[0] = '{1'b0, 8'd5,   8'd3,  4'h0, 8'd8,   4'b0000};
        vecs[1] = '{1'b1, 8'd127, 8'd1,  4'h0, 8'd128, 4'b0101};
        vecs[2] = '{1'b0, 8'hFF,  8'h01, 4'h0, 8'h00,  4'b1010};
        vecs[3] = '{1'b1, 8'h03,  8'h05, 4'h1, 8'hFE,  4'b1001};
        vecs[4] = '{1'b0, 8'hF0,  8'h0F, 4'h2, 8'h00,  4'b0010};

        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
        set_req(1'b1, 1'b0, 8'h0, 8'h0, 4'h0);
        step(); step();
        chk("reset_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        chk("reset_busy", 16'(bus.busy), 16'h0);
        chk("reset_alu_a", 16'(alu_a), 16'h0);
        chk("reset_rsp_result", 16'(bus.rsp_result), 16'h0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        step();

        // Single-requester operations from the vector table
        for (int i = 0; i < 5; i++) begin
            set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            #1;
            chk($sformatf("v%0d_ready", i), 16'({bus.req1_ready, bus.req0_ready}),
                vecs[i].id ? 16'h2 : 16'h1);
            step();
            set_req(vecs[i].id, 1'b0, 8'h0, 8'h0, 4'h0);
            chk($sformatf("v%0d_exec_busy", i), 16'(bus.busy), 16'h1);
            chk($sformatf("v%0d_exec_no_rsp", i), 16'(bus.rsp_valid), 16'h0);
            chk($sformatf("v%0d_alu_a", i), 16'(alu_a), 16'(vecs[i].a));
            step();
            chk($sformatf("v%0d_rsp_valid", i), 16'(bus.rsp_valid), 16'h1);
            chk($sformatf("v%0d_rsp_id", i), 16'(bus.rsp_id), 16'(vecs[i].id));
            chk($sformatf("v%0d_result", i), 16'(bus.rsp_result), 16'(vecs[i].exp_res));
            chk($sformatf("v%0d_flags", i), 16'(bus.rsp_flags), 16'(vecs[i].exp_flags));
            step();
            chk($sformatf("v%0d_idle", i), 16'({bus.busy, bus.rsp_valid}), 16'h0);
            chk($sformatf("v%0d_alu_hold", i), 16'(alu_b), 16'(vecs[i].b));
        end

        // Contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 8'd1,  8'd2,  4'h0);
        set_req(1'b1, 1'b1, 8'd10, 8'd20, 4'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_ready", k), 16'({bus.req1_ready, bus.req0_ready}),
                (k % 2) ? 16'h2 : 16'h1);
            step();
            chk($sformatf("rr%0d_exec_ready", k), 16'({bus.req1_ready, bus.req0_ready}), 16'h0);
            step();
            chk($sformatf("rr%0d_rsp_id", k), 16'(bus.rsp_id), 16'(k % 2));
            chk($sformatf("rr%0d_result", k), 16'(bus.rsp_result), (k % 2) ? 16'd30 : 16'd3);
            chk($sformatf("rr%0d_resp_ready", k), 16'({bus.req1_ready, bus.req0_ready}), 16'h0);
            step();
        end

        // Backpressure: response held for 5 cycles, requesters blocked
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'd9, 8'd9, 4'h0);
        #1;
        chk("bp_ready0", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
        step();
        set_req(1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
        step();
        chk("bp_rsp_valid", 16'(bus.rsp_valid), 16'h1);
        hold_res   = bus.rsp_result;
        hold_flags = bus.rsp_flags;
        chk("bp_result", 16'(hold_res), 16'd18);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("bp%0d_stable", c),
                16'({bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_result}),
                16'({1'b1, 1'b0, 4'b0000, 8'd18}));
            chk($sformatf("bp%0d_blocked", c),
                16'({bus.busy, bus.req1_ready, bus.req0_ready}), 16'h4);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_release", 16'({bus.busy, bus.rsp_valid}), 16'h0);
        chk("bp_next_ready1", 16'({bus.req1_ready, bus.req0_ready}), 16'h2);
        step();
        set_req(1'b1, 1'b0, 8'h0, 8'h0, 4'h0);
        step();
        chk("bp_after_id", 16'(bus.rsp_id), 16'h1);
        chk("bp_after_result", 16'(bus.rsp_result), 16'd30);
        step();

        // Reset while in EXEC drops the operation
        set_req(1'b1, 1'b1, 8'd7, 8'd7, 4'h0);
        step();
        set_req(1'b1, 1'b0, 8'h0, 8'h0, 4'h0);
        chk("mid_in_exec", 16'(bus.busy), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        chk("mid_busy", 16'(bus.busy), 16'h0);
        chk("mid_alu", 16'({alu_a, alu_b}), 16'h0);
        chk("mid_alu_op", 16'(alu_opcode), 16'h0);
`ifdef ALU_SHARE_ARB_CNT_EN
        chk("cnt_reset", 16'(gnt0_cnt | gnt1_cnt), 16'h0);
`endif
        step();
        chk("mid_no_rsp", 16'({bus.rsp_valid, bus.busy}), 16'h0);
        set_req(1'b0, 1'b1, 8'd2, 8'd2, 4'h0);
        set_req(1'b1, 1'b1, 8'd3, 8'd3, 4'h0);
        #1;
        chk("mid_first_grant", 16'({bus.req1_ready, bus.req0_ready}), 16'h1);
        step();
        set_req(1'b0, 1'b0, 8'h0, 8'h0, 4'h0);
        set_req(1'b1, 1'b0, 8'h0, 8'h0, 4'h0);
`ifdef ALU_SHARE_ARB_CNT_EN
        chk("cnt0_after", 16'(gnt0_cnt), 16'd1);
        chk("cnt1_after", 16'(gnt1_cnt), 16'd0);
`endif
        step();
        chk("mid_rsp_id", 16'(bus.rsp_id), 16'h0);
        chk("mid_rsp_result", 16'(bus.rsp_result), 16'd4);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU_8bit instance between two requesters. Each requester uses a valid/ready request channel.
- Arbitrates round-robin, registers the winning operands and opcode, and drives the ALU for one execute cycle.
- Captures the result and the four flags, then returns them on a single valid/ready response channel tagged with the requester ID.
- Sits between the two issue ports and the ALU datapath.

Parameters:
- WIDTH, 8, operand/result width; must match ALU_8bit.
- OPW, 4, opcode width.
- CNT_W, 16, width of the optional grant counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_op  in  OPW  opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above for requester 1.
- alu_a  out  WIDTH  to ALU a.
- alu_b  out  WIDTH  to ALU b.
- alu_opcode  out  OPW  to ALU opcode.
- alu_result  in  WIDTH  from ALU result.
- alu_cf, alu_of, alu_zf, alu_nf  in  1 each  ALU carry/overflow/zero/negative flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  4  {cf, of, zf, nf}.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states:
  - IDLE: accept a request.
  - EXEC: one cycle; the ALU evaluates the registered operands.
  - RESP: hold the response until it is taken.
- Reset (rst=1 at an edge): state=IDLE; rr_ptr=0; alu_a/alu_b/alu_opcode=0; rsp_valid=0; rsp_id=0; rsp_result=0; rsp_flags=0. Any in-flight operation is dropped silently, including one in EXEC or RESP.
- Ready generation: combinational, asserted only in IDLE and only for the granted requester. Ready depends on valid; requesters must not wait for ready before asserting valid.
- Grant rule in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester indicated by rr_ptr.
  - No valid: stay in IDLE.
- Acceptance edge (valid && ready): latch a/b/op into alu_a/alu_b/alu_opcode and the requester ID into id_q. Set rr_ptr = ~granted_id. Go to EXEC.
- EXEC edge: rsp_result <= alu_result; rsp_flags <= {alu_cf, alu_of, alu_zf, alu_nf}; rsp_id <= id_q; rsp_valid <= 1; go to RESP.
- RESP: rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE. There is no accept in the same cycle.
- Timing:
  - Accept at edge N gives rsp_valid high after edge N+1.
  - Best-case throughput is one operation per 3 cycles.
  - The earliest next req_ready is in the cycle after the response handshake.
- alu_* outputs hold their last value outside EXEC; they are not cleared after a response.
- Requester rules (verification checks these; no RTL checker): valid stays high and payload stays stable until accepted.
- Opcodes pass through unmodified. Result and flag semantics belong to ALU_8bit.

Optional Feature:
- Macro: ALU_SHARE_ARB_CNT_EN.
- Defined:
  - Adds outputs gnt0_cnt and gnt1_cnt, CNT_W bits each.
  - Each counter increments on its requester's acceptance edge and wraps from all-ones to 0.
  - Both counters clear on rst.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package alu_share_pkg: FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2), flag bit indices (CF=3, OF=2, ZF=1, NF=0), WIDTH/OPW defaults.
- One natural sub-module: rr_arb2. It takes two valid inputs and rr_ptr, and produces a one-hot grant plus the granted ID. It is combinational; the pointer register stays in the parent.

Test Plan:
- Single request: req0 a=8'd5, b=8'd3, op=4'h0 (ADD), rsp_ready=1.
  - req0_ready in the same cycle; rsp_valid 2 edges after acceptance.
  - rsp_id=0, rsp_result=8'd8, rsp_flags=4'b0000.
- Contention: req0 and req1 both valid from reset and kept valid for 4 operations.
  - Grant order is 0,1,0,1; rsp_id sequence matches.
  - The loser's ready stays 0 until its turn.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_result/rsp_flags/rsp_id are stable.
  - req*_ready stays 0; busy=1.
  - Raising rsp_ready returns to IDLE on the next edge.
- Flags capture: a=8'd127, b=8'd1, ADD.
  - rsp_result=8'd128, rsp_flags={cf=0, of=1, zf=0, nf=1}.
- Zero/carry: a=8'hFF, b=8'h01, ADD.
  - rsp_result=0, rsp_flags={cf=1, of=0, zf=1, nf=0}.
- Reset mid-operation: assert rst in EXEC.
  - After the edge: rsp_valid=0, busy=0, alu_*=0, no response emitted.
  - With both requesters then valid, the first grant goes to req0.
  - With ALU_SHARE_ARB_CNT_EN defined: counters read 0 after reset, then 1/0 after the first grant.
